mtr_drv: RTL and testbench

- Downstream stage of the brushless commutation block. Consumes its 11-bit duty and the 2-bit per-phase selects (selGrn/selYlw/selBlu).
- Generates the 11-bit PWM carrier and drives six high/low gate signals to the three-phase bridge, with per-phase dead-time (non-overlap) insertion.
- Produces PWM_synch, the once-per-period strobe that the commutation block uses to sample the hall inputs.

---
 rtl/mtr_drv.sv | 106 ++++++++++
 tb/tb_mtr_drv.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mtr_drv.sv
// Three-phase bridge driver: 11-bit PWM carrier, per-phase request mux and
// dead-time (non-overlap) insertion on the six gate outputs.
module mtr_drv #(
    parameter int DEAD = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] duty,
    input  logic [1:0]  selGrn,
    input  logic [1:0]  selYlw,
    input  logic [1:0]  selBlu,
    output logic        highGrn,
    output logic        lowGrn,
    output logic        highYlw,
    output logic        lowYlw,
    output logic        highBlu,
    output logic        lowBlu,
    output logic        PWM_synch
);

    localparam logic [5:0] DEAD_LAST = 6'(DEAD - 1);

    logic [10:0] cnt;
    logic        PWM_sig;

    logic [1:0]  sel [3];
    logic [2:0]  req_h;
    logic [2:0]  req_l;
    logic [2:0]  prev_h;
    logic [2:0]  prev_l;
    logic [2:0]  changed;
    logic [2:0]  high;
    logic [2:0]  low;
    logic [5:0]  dcnt [3];

    // Free-running carrier; PWM_synch marks the first clock of each period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            PWM_sig   <= 1'b0;
            PWM_synch <= 1'b0;
        end else begin
            cnt       <= cnt + 11'd1;
            PWM_sig   <= (cnt < duty);
            PWM_synch <= (cnt == 11'h7FF);
        end
    end

    assign sel[0] = selGrn;
    assign sel[1] = selYlw;
    assign sel[2] = selBlu;

    always_comb begin
        req_h = '0;
        req_l = '0;
        for (int i = 0; i < 3; i++) begin
            case (sel[i])
                2'b10:   begin req_h[i] = PWM_sig;  req_l[i] = ~PWM_sig; end
                2'b01:   begin req_h[i] = ~PWM_sig; req_l[i] = PWM_sig;  end
                2'b11:   begin req_h[i] = 1'b0;     req_l[i] = PWM_sig;  end
                default: begin req_h[i] = 1'b0;     req_l[i] = 1'b0;     end
            endcase
        end
    end

    assign changed = (req_h ^ prev_h) | (req_l ^ prev_l);

    // Any request change cuts both gates at once; a request is only passed
    // through after it has held steady for the full dead-time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_h <= '0;
            prev_l <= '0;
            high   <= '0;
            low    <= '0;
            for (int i = 0; i < 3; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            prev_h <= req_h;
            prev_l <= req_l;
            for (int i = 0; i < 3; i++) begin
                if (changed[i]) begin
                    high[i] <= 1'b0;
                    low[i]  <= 1'b0;
                    dcnt[i] <= '0;
                end else if (dcnt[i] < DEAD_LAST) begin
                    high[i] <= 1'b0;
                    low[i]  <= 1'b0;
                    dcnt[i] <= dcnt[i] + 6'd1;
                end else begin
                    high[i] <= req_h[i];
                    low[i]  <= req_l[i];
                end
            end
        end
    end

    assign highGrn = high[0];
    assign lowGrn  = low[0];
    assign highYlw = high[1];
    assign lowYlw  = low[1];
    assign highBlu = high[2];
    assign lowBlu  = low[2];

endmodule

// File: tb/tb_mtr_drv.sv
// Self-checking bench for mtr_drv: cycle-indexed reference model of carrier,
// requests and dead-time, driven by directed and random sel/duty sequences.
module tb_mtr_drv;

    localparam int DEAD = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] duty;
    logic [1:0]  selGrn, selYlw, selBlu;
    logic        highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu;
    logic        PWM_synch;

    int checks = 0;
    int errors = 0;

    int          k;
    logic        pwmM;
    logic [10:0] dutyHold;
    logic [1:0]  hist [3];
    int          lastChg [3];
    int          cntG [6];
    int          holdLeft;

    mtr_drv #(.DEAD(DEAD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .duty     (duty),
        .selGrn   (selGrn),
        .selYlw   (selYlw),
        .selBlu   (selBlu),
        .highGrn  (highGrn),
        .lowGrn   (lowGrn),
        .highYlw  (highYlw),
        .lowYlw   (lowYlw),
        .highBlu  (highBlu),
        .lowBlu   (lowBlu),
        .PWM_synch(PWM_synch)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    // Request pair {H,L} a phase asks for, given its mode and the PWM level.
    function automatic logic [1:0] reqOf(input logic [1:0] sel, input logic pwm);
        case (sel)
            2'b10:   return {pwm, ~pwm};
            2'b01:   return {~pwm, pwm};
            2'b11:   return {1'b0, pwm};
            default: return 2'b00;
        endcase
    endfunction

    task automatic modelReset();
        k    = 0;
        pwmM = 1'b0;
        for (int p = 0; p < 3; p++) begin
            hist[p]    = 2'b00;
            lastChg[p] = -100000;
        end
    endtask

    task automatic clearCounts();
        for (int g = 0; g < 6; g++) cntG[g] = 0;
    endtask

    // Model: gates after edge k+1 show request r(k) only when r has not
    // changed for at least DEAD cycles; PWM level after edge k+1 is
    // (k mod 2048) < duty held during cycle k.
    task automatic applyStimulus(input int n, input bit rnd);
        logic [1:0] s [3];
        logic [1:0] r;
        logic [1:0] e [3];
        logic       pwmNew;
        logic [6:0] expv, gotv;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                if (holdLeft <= 0) begin
                    duty     = 11'($urandom_range(0, 2047));
                    selGrn   = 2'($urandom_range(0, 3));
                    selYlw   = 2'($urandom_range(0, 3));
                    selBlu   = 2'($urandom_range(0, 3));
                    holdLeft = $urandom_range(1, 100);
                end
                holdLeft--;
            end
            s[0] = selGrn;
            s[1] = selYlw;
            s[2] = selBlu;
            for (int p = 0; p < 3; p++) begin
                r = reqOf(s[p], pwmM);
                if (r != hist[p]) lastChg[p] = k;
                hist[p] = r;
            end
            dutyHold = duty;
            @(posedge clk);
            #1;
            for (int p = 0; p < 3; p++) begin
                e[p] = ((k - lastChg[p]) >= DEAD) ? hist[p] : 2'b00;
            end
            pwmNew = ((k % 2048) < int'(dutyHold));
            expv = {((k % 2048) == 2047), e[0], e[1], e[2]};
            gotv = {PWM_synch, highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu};
            checkOutput("gates", 32'(gotv), 32'(expv));
            checkOutput("overlap", 32'({highGrn & lowGrn, highYlw & lowYlw, highBlu & lowBlu}), 32'd0);
            cntG[0] += int'(highGrn);
            cntG[1] += int'(lowGrn);
            cntG[2] += int'(highYlw);
            cntG[3] += int'(lowYlw);
            cntG[4] += int'(highBlu);
            cntG[5] += int'(lowBlu);
            k++;
            pwmM = pwmNew;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        duty     = 11'h400;
        selGrn   = 2'b10;
        selYlw   = 2'b00;
        selBlu   = 2'b00;
        holdLeft = 0;
        k        = 0;
        #23;
        checkOutput("reset", 32'({PWM_synch, highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();

        // 50% duty forward on green: 992 high and 992 low clocks per period
        applyStimulus(2 * 2048, 1'b0);
        clearCounts();
        applyStimulus(2048, 1'b0);
        checkOutput("grnHighCnt", 32'(cntG[0]), 32'd992);
        checkOutput("grnLowCnt", 32'(cntG[1]), 32'd992);
        checkOutput("ylwBluIdle", 32'(cntG[2] + cntG[3] + cntG[4] + cntG[5]), 32'd0);

        // Regen brake on green
        duty   = 11'h600;
        selGrn = 2'b11;
        applyStimulus(2 * 2048, 1'b0);
        clearCounts();
        applyStimulus(2048, 1'b0);
        checkOutput("brakeHighCnt", 32'(cntG[0]), 32'd0);
        checkOutput("brakeLowCnt", 32'(cntG[1]), 32'd1504);

        // Reverse yellow at duty 0 from a fresh reset, then forward at full duty
        rst_n  = 1'b0;
        duty   = 11'h000;
        selGrn = 2'b00;
        selYlw = 2'b01;
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        applyStimulus(2 * 2048, 1'b0);
        duty   = 11'h7FF;
        selYlw = 2'b10;
        applyStimulus(2 * 2048, 1'b0);
        clearCounts();
        applyStimulus(2048, 1'b0);
        checkOutput("ylwFullHighCnt", 32'(cntG[2]), 32'd2015);

        // Mid-period direction change on blue
        selYlw = 2'b00;
        selBlu = 2'b10;
        duty   = 11'h200;
        applyStimulus(1000, 1'b0);
        selBlu = 2'b01;
        applyStimulus(3000, 1'b0);

        // Random sel/duty, held 1..100 clocks each
        applyStimulus(12000, 1'b1);

        // Reset asserted near cnt 0x300 with gates active
        duty   = 11'h400;
        selGrn = 2'b10;
        selYlw = 2'b01;
        selBlu = 2'b11;
        applyStimulus(2048 + ((16'h300 - (k % 2048) + 2048) % 2048), 1'b0);
        checkOutput("preRstActive", 32'(highGrn | lowYlw | lowBlu), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset", 32'({PWM_synch, highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        applyStimulus(2100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
